// File: rtl/cdma_pkg.sv
// cdma_pkg: shared constants, register map, FSM state type and the burst
// sizing helpers for the central DMA engine.
package cdma_pkg;

  // APB register word indices (paddr[7:2])
  localparam logic [5:0] REG_CTRL   = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam logic [5:0] REG_SRC    = 6'h02;
  localparam logic [5:0] REG_DST    = 6'h03;
  localparam logic [5:0] REG_LEN    = 6'h04;

  localparam int CTRL_START = 0;
  localparam int CTRL_IE    = 1;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  localparam int MAX_BEATS = 16;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_FIN
  } state_e;

  // Words left before the next 4 KB page boundary (1..1024).
  function automatic logic [10:0] words_to_4k(input logic [31:0] addr);
    logic [12:0] gap;
    gap = 13'h1000 - {1'b0, addr[11:0]};
    return gap[12:2];
  endfunction

  // Beats for the next read/write pair: capped by MAX_BEATS, the remaining
  // word count and both page boundaries. rem is never 0 when this is used.
  function automatic logic [4:0] burst_beats(input logic [29:0] rem,
                                             input logic [31:0] src,
                                             input logic [31:0] dst);
    logic [29:0] b;
    b = 30'(MAX_BEATS);
    if (rem < b) b = rem;
    if (30'(words_to_4k(src)) < b) b = 30'(words_to_4k(src));
    if (30'(words_to_4k(dst)) < b) b = 30'(words_to_4k(dst));
    return b[4:0];
  endfunction

endpackage

// File: rtl/cdma_fifo.sv
// cdma_fifo: 16 x 32 synchronous FIFO holding one burst of read data until
// it is written out.
//   clk, rstn     clock, async active-low reset (clears pointers only)
//   push, din     write side; push ignored when full
//   pop, dout     read side; dout shows the head word, pop ignored when empty
//   full, empty, count  occupancy
module cdma_fifo import cdma_pkg::*; (
  input  logic        clk,
  input  logic        rstn,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty,
  output logic [4:0]  count
);

  logic [31:0] mem [MAX_BEATS];
  logic [3:0]  wp, rp;
  logic [4:0]  cnt;
  logic        do_push, do_pop;

  assign full    = (cnt == 5'(MAX_BEATS));
  assign empty   = (cnt == 5'd0);
  assign count   = cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 4'd1;
      if (do_pop)  rp <= rp + 4'd1;
      cnt <= cnt + 5'(do_push) - 5'(do_pop);
    end
  end

endmodule

// File: rtl/cdma_engine.sv
// cdma_engine: APB-programmed memory-to-memory copy engine with an AXI3
// 32-bit master. Copies LEN bytes from SRC to DST as read/write burst pairs
// of up to 16 beats, never crossing a 4 KB page on either side.
//   clk, rstn                     clock, async active-low reset
//   psel/penable/pwrite/paddr/pwdata/pready/prdata   APB slave (0 wait)
//   ar*/r*                        AXI read address / data channels
//   aw*/w*/b*                     AXI write address / data / response
//   intr                          level interrupt = DONE & IE
module cdma_engine import cdma_pkg::*; (
  input  logic        clk,
  input  logic        rstn,
  // APB
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic [31:0] prdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  // interrupt
  output logic        intr
);

  // Fixed AXI attributes
  assign arid    = '0;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign awid    = '0;
  assign awsize  = SIZE_4B;
  assign awburst = BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign wid     = '0;
  assign wstrb   = 4'hF;
  assign pready  = 1'b1;

  // Programmed registers and status
  logic        ctrl_ie;
  logic        st_busy, st_done, st_err;
  logic [31:0] src_q, dst_q, len_q;

  // Transfer state
  state_e      state;
  logic [31:0] cur_src, cur_dst;
  logic [29:0] rem;           // words still to copy
  logic [4:0]  beats_q;       // beats of the pair in flight
  logic [4:0]  beats_c;
  logic [3:0]  wcnt;
  logic        abort_q;       // a slave error was seen; stop after this pair

  // APB decode
  logic [5:0] reg_idx;
  logic       apb_wr, start_req, w1c_done, w1c_err;

  assign reg_idx   = paddr[7:2];
  assign apb_wr    = psel & penable & pwrite;
  assign start_req = apb_wr && (reg_idx == REG_CTRL) && pwdata[CTRL_START] && !st_busy;
  assign w1c_done  = apb_wr && (reg_idx == REG_STATUS) && pwdata[ST_DONE];
  assign w1c_err   = apb_wr && (reg_idx == REG_STATUS) && pwdata[ST_ERR];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_ie <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
    end else if (apb_wr) begin
      unique case (reg_idx)
        REG_CTRL: ctrl_ie <= pwdata[CTRL_IE];
        REG_SRC:  if (!st_busy) src_q <= {pwdata[31:2], 2'b00};
        REG_DST:  if (!st_busy) dst_q <= {pwdata[31:2], 2'b00};
        REG_LEN:  if (!st_busy) len_q <= {pwdata[31:2], 2'b00};
        default: ;
      endcase
    end
  end

  always_comb begin
    prdata = '0;
    if (psel && penable && !pwrite) begin
      unique case (reg_idx)
        REG_CTRL:   prdata[CTRL_IE] = ctrl_ie;
        REG_STATUS: prdata[2:0] = {st_err, st_done, st_busy};
        REG_SRC:    prdata = src_q;
        REG_DST:    prdata = dst_q;
        REG_LEN:    prdata = len_q;
        default:    prdata = '0;
      endcase
    end
  end

  assign intr = st_done & ctrl_ie;

  // Burst buffer
  logic        fifo_empty, fifo_full;
  logic [4:0]  fifo_count;
  logic        push, pop;

  assign push = rvalid & rready;
  assign pop  = wvalid & wready;

  cdma_fifo u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (rdata),
    .pop   (pop),
    .dout  (wdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign beats_c = burst_beats(rem, cur_src, cur_dst);
  assign wvalid  = (state == S_WR_DATA) && !fifo_empty;
  assign wlast   = wvalid && (wcnt == 4'(beats_q - 5'd1));

  // Transfer FSM. DONE/ERR W1C is applied first so a same-cycle set wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      st_busy <= 1'b0;
      st_done <= 1'b0;
      st_err  <= 1'b0;
      abort_q <= 1'b0;
      cur_src <= '0;
      cur_dst <= '0;
      rem     <= '0;
      beats_q <= '0;
      wcnt    <= '0;
      arvalid <= 1'b0;
      araddr  <= '0;
      arlen   <= '0;
      awvalid <= 1'b0;
      awaddr  <= '0;
      awlen   <= '0;
      rready  <= 1'b0;
      bready  <= 1'b0;
    end else begin
      if (w1c_done) st_done <= 1'b0;
      if (w1c_err)  st_err  <= 1'b0;
      unique case (state)
        S_IDLE: if (start_req) begin
          st_busy <= 1'b1;
          st_done <= 1'b0;
          st_err  <= 1'b0;
          abort_q <= 1'b0;
          cur_src <= src_q;
          cur_dst <= dst_q;
          rem     <= len_q[31:2];
          state   <= (len_q[31:2] == '0) ? S_FIN : S_RD_ADDR;
        end
        S_RD_ADDR: begin
          if (!arvalid) begin
            arvalid <= 1'b1;
            araddr  <= cur_src;
            arlen   <= 4'(beats_c - 5'd1);
            beats_q <= beats_c;
          end else if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: if (rvalid) begin
          // An errored burst is still drained and written back out.
          if (rresp != 2'b00) begin
            abort_q <= 1'b1;
            st_err  <= 1'b1;
          end
          if (rlast) begin
            rready <= 1'b0;
            state  <= S_WR_ADDR;
          end
        end
        S_WR_ADDR: begin
          if (!awvalid) begin
            awvalid <= 1'b1;
            awaddr  <= cur_dst;
            awlen   <= 4'(beats_q - 5'd1);
          end else if (awready) begin
            awvalid <= 1'b0;
            wcnt    <= '0;
            state   <= S_WR_DATA;
          end
        end
        S_WR_DATA: if (pop) begin
          wcnt <= wcnt + 4'd1;
          if (wlast) begin
            bready <= 1'b1;
            state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: if (bvalid) begin
          bready  <= 1'b0;
          cur_src <= cur_src + 32'({beats_q, 2'b00});
          cur_dst <= cur_dst + 32'({beats_q, 2'b00});
          rem     <= rem - 30'(beats_q);
          if (bresp != 2'b00) begin
            abort_q <= 1'b1;
            st_err  <= 1'b1;
          end
          if (rem == 30'(beats_q) || abort_q || bresp != 2'b00) state <= S_FIN;
          else                                                   state <= S_RD_ADDR;
        end
        S_FIN: begin
          st_done <= 1'b1;
          st_busy <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused_in;
  assign unused_in = ^{rid, bid, paddr[1:0], fifo_full, fifo_count};

endmodule

// File: tb/tb_cdma_engine.sv
module tb_cdma_engine;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        psel = 0, penable = 0, pwrite = 0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pready;
  logic [31:0] prdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready, intr;
  logic        arready = 0, awready = 0, wready = 0, rvalid = 0, rlast = 0, bvalid = 0;
  logic [3:0]  rid = '0, bid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;

  always #5 clk = ~clk;

  cdma_engine dut (
    .clk(clk), .rstn(rstn),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .intr(intr)
  );

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- AXI slave memory model ----------------
  typedef struct { logic [31:0] addr; logic [3:0] len; } burst_t;
  burst_t ar_q[$], aw_q[$], ar_log[$], aw_log[$];
  logic [31:0] mem     [0:4095];
  logic [31:0] exp_mem [0:4095];
  int  rd_beat = 0, w_beat = 0, b_pend = 0, rd_done = 0, wlast_bad = 0;
  int  rdy_pct = 70;
  bit  err_first = 0;

  function automatic int word(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  // Observe handshakes on the edge (pre-update values).
  always @(posedge clk) begin
    burst_t t;
    if (arvalid && arready) begin
      t.addr = araddr; t.len = arlen;
      ar_q.push_back(t); ar_log.push_back(t);
    end
    if (rvalid && rready) begin
      if (rlast) begin ar_q.delete(0); rd_beat = 0; rd_done++; end
      else rd_beat++;
    end
    if (awvalid && awready) begin
      t.addr = awaddr; t.len = awlen;
      aw_q.push_back(t); aw_log.push_back(t);
    end
    if (wvalid && wready) begin
      if (aw_q.size() == 0) wlast_bad++;
      else begin
        mem[word(aw_q[0].addr + 32'(4 * w_beat))] = wdata;
        if (wlast !== (w_beat == int'(aw_q[0].len))) wlast_bad++;
        if (w_beat == int'(aw_q[0].len)) begin aw_q.delete(0); w_beat = 0; b_pend++; end
        else w_beat++;
      end
    end
    if (bvalid && bready) b_pend--;
  end

  // Drive slave inputs half a cycle away from the sampling edge.
  initial forever begin
    @(negedge clk);
    arready = ($urandom_range(0, 99) < rdy_pct);
    awready = ($urandom_range(0, 99) < rdy_pct);
    wready  = ($urandom_range(0, 99) < rdy_pct);
    if (ar_q.size() > 0 && $urandom_range(0, 99) < rdy_pct) begin
      rvalid = 1;
      rdata  = mem[word(ar_q[0].addr + 32'(4 * rd_beat))];
      rlast  = (rd_beat == int'(ar_q[0].len));
      rresp  = (err_first && rd_done == 0) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 0; rlast = 0; rresp = 2'b00; rdata = '0;
    end
    bvalid = (b_pend > 0);
    bresp  = 2'b00;
  end

  // ---------------- APB helpers ----------------
  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(negedge clk); penable = 1;
    @(negedge clk); psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(negedge clk); penable = 1; #1 d = prdata;
    @(negedge clk); psel = 0; penable = 0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    int n = 0;
    do begin apb_rd(8'h04, st); n++; end while (st[0] && n < 3000);
    check({tag, "_busy_timeout"}, {31'b0, st[0]}, 32'd0);
  endtask

  // Fill source, build expected memory image, program and start.
  task automatic start_copy(input logic [31:0] s, d, l, input bit ie);
    for (int i = 0; i < int'(l / 4); i++) mem[word(s + 32'(4 * i))] = $urandom;
    exp_mem = mem;
    for (int i = 0; i < int'(l / 4); i++)
      exp_mem[word(d + 32'(4 * i))] = mem[word(s + 32'(4 * i))];
    ar_log.delete(); aw_log.delete(); rd_done = 0; wlast_bad = 0;
    apb_wr(8'h08, s); apb_wr(8'h0C, d); apb_wr(8'h10, l);
    apb_wr(8'h00, {30'b0, ie, 1'b1});
  endtask

  // Reference: split the copy by the 16-beat / remaining / 4 KB rules.
  task automatic check_copy(input string tag, input logic [31:0] s, d, l, input bit ie);
    burst_t er[$], ew[$], t;
    int cs = int'(s), cd = int'(d), r = int'(l / 4), b, bad = 0, mbad = 0;
    logic [31:0] st;
    while (r > 0) begin
      b = 16;
      if (r < b) b = r;
      if ((4096 - cs % 4096) / 4 < b) b = (4096 - cs % 4096) / 4;
      if ((4096 - cd % 4096) / 4 < b) b = (4096 - cd % 4096) / 4;
      t.len = 4'(b - 1);
      t.addr = 32'(cs); er.push_back(t);
      t.addr = 32'(cd); ew.push_back(t);
      cs += 4 * b; cd += 4 * b; r -= b;
    end
    check({tag, "_ar_count"}, ar_log.size(), er.size());
    check({tag, "_aw_count"}, aw_log.size(), ew.size());
    for (int i = 0; i < er.size() && i < ar_log.size(); i++)
      if (ar_log[i].addr !== er[i].addr || ar_log[i].len !== er[i].len) bad++;
    for (int i = 0; i < ew.size() && i < aw_log.size(); i++)
      if (aw_log[i].addr !== ew[i].addr || aw_log[i].len !== ew[i].len) bad++;
    check({tag, "_burst_addr_len_bad"}, bad, 0);
    for (int i = 0; i < 4096; i++) if (mem[i] !== exp_mem[i]) mbad++;
    check({tag, "_mem_bad_words"}, mbad, 0);
    check({tag, "_wlast_bad"}, wlast_bad, 0);
    apb_rd(8'h04, st);
    check({tag, "_status"}, st, 32'h2);
    check({tag, "_intr"}, {31'b0, intr}, {31'b0, ie});
  endtask

  typedef struct {
    logic [31:0] src, dst, len;
    int          nb;
    logic [3:0]  arlen0;
    logic [31:0] last_ar;
  } vec_t;

  initial begin
    vec_t vt[3];
    logic [31:0] rd;
    logic [31:0] s, d, l;

    for (int i = 0; i < 4096; i++) mem[i] = $urandom;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_arvalid", {31'b0, arvalid}, 0);
    check("rst_awvalid", {31'b0, awvalid}, 0);
    check("rst_wvalid",  {31'b0, wvalid}, 0);
    check("rst_rready",  {31'b0, rready}, 0);
    check("rst_bready",  {31'b0, bready}, 0);
    check("rst_intr",    {31'b0, intr}, 0);
    check("rst_prdata",  prdata, 0);
    rstn = 1;
    check("const_pready", {31'b0, pready}, 1);
    check("const_arsize", {29'b0, arsize}, 2);
    check("const_awburst", {30'b0, awburst}, 1);
    check("const_wstrb", {28'b0, wstrb}, 32'hF);
    apb_rd(8'h04, rd); check("rst_status", rd, 0);
    apb_rd(8'h08, rd); check("rst_src", rd, 0);
    apb_rd(8'h10, rd); check("rst_len", rd, 0);

    // ---- register readback ----
    apb_wr(8'h00, 32'h2);  apb_rd(8'h00, rd); check("ctrl_ie_readback", rd, 32'h2);
    apb_wr(8'h0C, 32'h1237); apb_rd(8'h0C, rd); check("dst_low_bits_forced", rd, 32'h1234);
    apb_wr(8'h14, 32'hFFFF); apb_rd(8'h14, rd); check("unmapped_reads_zero", rd, 0);

    // ---- table-driven directed copies ----
    vt[0] = '{32'h1000, 32'h2000, 32'd64, 1, 4'd15, 32'h1000};
    vt[1] = '{32'h0FF8, 32'h3000, 32'd80, 3, 4'd1,  32'h1040};
    vt[2] = '{32'h0100, 32'h2100, 32'd4,  1, 4'd0,  32'h0100};
    for (int v = 0; v < 3; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      start_copy(vt[v].src, vt[v].dst, vt[v].len, 1'b1);
      wait_idle(tag);
      check({tag, "_nbursts"}, ar_log.size(), vt[v].nb);
      check({tag, "_arlen0"}, (ar_log.size() > 0) ? {28'b0, ar_log[0].len} : 32'hFFFF_FFFF,
            {28'b0, vt[v].arlen0});
      check({tag, "_last_araddr"}, (ar_log.size() > 0) ? ar_log[ar_log.size()-1].addr : 32'hFFFF_FFFF,
            vt[v].last_ar);
      check_copy(tag, vt[v].src, vt[v].dst, vt[v].len, 1'b1);
    end

    // ---- W1C DONE drops intr the next cycle; new START still works ----
    apb_wr(8'h04, 32'h2);
    check("w1c_intr_low", {31'b0, intr}, 0);
    apb_rd(8'h04, rd); check("w1c_status", rd, 0);
    start_copy(32'h0300, 32'h2300, 32'd32, 1'b1);
    wait_idle("after_w1c");
    check_copy("after_w1c", 32'h0300, 32'h2300, 32'd32, 1'b1);

    // ---- LEN=0: DONE without AXI traffic ----
    ar_log.delete(); aw_log.delete();
    apb_wr(8'h10, 32'h0);
    apb_wr(8'h00, 32'h3);
    apb_rd(8'h04, rd); check("len0_status", rd, 32'h2);
    check("len0_ar_count", ar_log.size(), 0);
    check("len0_intr", {31'b0, intr}, 1);

    // ---- read error on first burst of a 128 B copy ----
    err_first = 1;
    start_copy(32'h0200, 32'h2400, 32'd128, 1'b0);
    wait_idle("rerr");
    err_first = 0;
    apb_rd(8'h04, rd); check("rerr_status", rd, 32'h6);
    check("rerr_ar_count", ar_log.size(), 1);
    check("rerr_aw_count", aw_log.size(), 1);
    apb_wr(8'h04, 32'h4);
    apb_rd(8'h04, rd); check("rerr_w1c_err", rd, 32'h2);

    // ---- SRC write and START while BUSY are ignored ----
    start_copy(32'h0400, 32'h2800, 32'd256, 1'b0);
    apb_rd(8'h04, rd); check("busy_seen", {31'b0, rd[0]}, 1);
    apb_wr(8'h08, 32'h0800);
    apb_wr(8'h00, 32'h1);
    wait_idle("busy_ign");
    check_copy("busy_ign", 32'h0400, 32'h2800, 32'd256, 1'b0);
    apb_rd(8'h08, rd); check("busy_src_kept", rd, 32'h0400);

    // ---- randomized copies with random slave back-pressure ----
    for (int k = 0; k < 8; k++) begin
      string tag;
      tag = $sformatf("rand%0d", k);
      rdy_pct = $urandom_range(30, 100);
      s = 32'(4 * $urandom_range(0, 'h1BFC / 4));
      d = 32'h2000 + 32'(4 * $urandom_range(0, 'h1BFC / 4));
      l = 32'(4 * $urandom_range(1, 256));
      start_copy(s, d, l, k[0]);
      wait_idle(tag);
      check_copy(tag, s, d, l, k[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
